// File: rtl/rgb_palette_encoder_if.sv
// Pixel-in / palette-result-out handshake bundle for rgb_palette_encoder.
// master = surrounding logic, slave = the encoder.
interface rgb_palette_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_rgb;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_color;
    logic [9:0]  out_dist;
    logic        out_exact;

    modport master (
        output in_valid, in_rgb, out_ready,
        input  in_ready, out_valid, out_color, out_dist, out_exact
    );

    modport slave (
        input  in_valid, in_rgb, out_ready,
        output in_ready, out_valid, out_color, out_dist, out_exact
    );
endinterface

// File: rtl/rgb_palette_encoder.sv
// Nearest-entry (Manhattan) search of a 24-bit pixel over the fixed 8-colour sprite palette, one entry per cycle;
// result 2..9 cycles after accept (exact hit ends early), held until out_ready; no new pixel until the result is taken.
module rgb_palette_encoder (
    input  logic                  clk,
    input  logic                  rst,
    rgb_palette_encoder_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [23:0] r_pix;
    logic [2:0]  r_idx;
    logic [9:0]  r_best_dist;
    logic [2:0]  r_best_idx;
    logic        r_out_valid;
    logic [2:0]  r_out_color;
    logic [9:0]  r_out_dist;
    logic        r_out_exact;

    logic        w_in_ready;
    logic        w_accept;
    logic        w_load_out;
    logic        w_release;
    logic [23:0] w_entry;
    logic [7:0]  w_dr;
    logic [7:0]  w_dg;
    logic [7:0]  w_db;
    logic [9:0]  w_dist;
    logic        w_better;
    logic [9:0]  w_fin_dist;
    logic [2:0]  w_fin_idx;
    logic        w_last;

    function automatic logic [23:0] palette(input logic [2:0] i);
        case (i)
            3'd0:    palette = 24'hAAAAAA;
            3'd1:    palette = 24'h000000;
            3'd2:    palette = 24'hFFFFFF;
            3'd3:    palette = 24'hFF1551;
            3'd4:    palette = 24'hBF8718;
            3'd5:    palette = 24'h5EFF00;
            3'd6:    palette = 24'h008FFF;
            default: palette = 24'h02006B;
        endcase
    endfunction

    function automatic logic [7:0] absdiff(input logic [7:0] a, input logic [7:0] b);
        absdiff = (a > b) ? (a - b) : (b - a);
    endfunction

    // Distance of the captured pixel to the entry under evaluation this cycle.
    assign w_entry    = palette(r_idx);
    assign w_dr       = absdiff(r_pix[23:16], w_entry[23:16]);
    assign w_dg       = absdiff(r_pix[15:8],  w_entry[15:8]);
    assign w_db       = absdiff(r_pix[7:0],   w_entry[7:0]);
    assign w_dist     = {2'b00, w_dr} + {2'b00, w_dg} + {2'b00, w_db};

    // Strict less-than keeps the earlier (lower) index on a tie.
    assign w_better   = (w_dist < r_best_dist);
    assign w_fin_dist = w_better ? w_dist : r_best_dist;
    assign w_fin_idx  = w_better ? r_idx  : r_best_idx;
    assign w_last     = (w_dist == 10'd0) || (r_idx == 3'd7);

    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_release  = r_out_valid & bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_load_out  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = ~rst;
                if (bus.in_valid && !rst) begin
                    w_state_nxt = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (w_last) begin
                    w_load_out  = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (w_release) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pix       <= 24'd0;
            r_idx       <= 3'd0;
            r_best_dist <= 10'd1023;
            r_best_idx  <= 3'd0;
        end else if (w_accept) begin
            r_pix       <= bus.in_rgb;
            r_idx       <= 3'd0;
            r_best_dist <= 10'd1023;
            r_best_idx  <= 3'd0;
        end else if (r_state == S_SEARCH) begin
            r_best_dist <= w_fin_dist;
            r_best_idx  <= w_fin_idx;
            if (!w_last) begin
                r_idx <= r_idx + 3'd1;
            end
        end
    end

    // Result registers keep their last value outside DONE; only out_valid qualifies them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_color <= 3'd0;
            r_out_dist  <= 10'd0;
            r_out_exact <= 1'b0;
        end else if (w_load_out) begin
            r_out_valid <= 1'b1;
            r_out_color <= w_fin_idx;
            r_out_dist  <= w_fin_dist;
            r_out_exact <= (w_fin_dist == 10'd0);
        end else if (w_release) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_color = r_out_color;
    assign bus.out_dist  = r_out_dist;
    assign bus.out_exact = r_out_exact;

endmodule

// File: tb/tb_rgb_palette_encoder.sv
// Directed and randomised checks of rgb_palette_encoder against hand-computed values and a nearest-colour model.
module tb_rgb_palette_encoder;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_bad;
    logic [23:0] pal [0:7];

    rgb_palette_encoder_if bus ();

    rgb_palette_encoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of cycle 1 (accept cycle is cycle 0).
    task automatic send(input logic [23:0] rgb);
        int g;
        g = 0;
        bus.in_valid = 1'b1;
        bus.in_rgb   = rgb;
        while (!bus.in_ready && g < 40) begin
            @(negedge clk);
            g++;
        end
        if (g >= 40) chk("accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_rgb   = ~rgb;
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic expect_res(input string tag, input logic [2:0] c, input logic [9:0] d,
                              input logic x, input int elat);
        int lat;
        wait_out(lat);
        chk({tag, "_lat"},   lat, elat);
        chk({tag, "_valid"}, bus.out_valid, 1'b1);
        chk({tag, "_color"}, bus.out_color, c);
        chk({tag, "_dist"},  bus.out_dist, d);
        chk({tag, "_exact"}, bus.out_exact, x);
        chk({tag, "_rdy_lo"}, bus.in_ready, 1'b0);
    endtask

    task automatic model(input logic [23:0] p, output logic [2:0] c, output logic [9:0] d);
        int best;
        int s;
        int dr;
        int dg;
        int db;
        best = 100000;
        c = 3'd0;
        for (int i = 0; i < 8; i++) begin
            dr = int'(p[23:16]) - int'(pal[i][23:16]);
            dg = int'(p[15:8])  - int'(pal[i][15:8]);
            db = int'(p[7:0])   - int'(pal[i][7:0]);
            if (dr < 0) dr = -dr;
            if (dg < 0) dg = -dg;
            if (db < 0) db = -db;
            s = dr + dg + db;
            if (s < best) begin
                best = s;
                c = 3'(i);
            end
        end
        d = 10'(best);
    endtask

    initial begin
        int lat;
        int cnt;
        int hold;
        logic [23:0] p;
        logic [2:0]  mc;
        logic [9:0]  md;

        pal[0] = 24'hAAAAAA; pal[1] = 24'h000000; pal[2] = 24'hFFFFFF; pal[3] = 24'hFF1551;
        pal[4] = 24'hBF8718; pal[5] = 24'h5EFF00; pal[6] = 24'h008FFF; pal[7] = 24'h02006B;
        n_chk = 0;
        n_bad = 0;
        clk = 1'b0;
        rst = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_rgb    = 24'd0;
        bus.out_ready = 1'b0;

        #1 rst = 1'b1;
        #1;
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_valid",    bus.out_valid, 1'b0);
        chk("rst_color",    bus.out_color, 3'd0);
        chk("rst_dist",     bus.out_dist, 10'd0);
        chk("rst_exact",    bus.out_exact, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);

        // Exact hit at index 3, single-cycle out_valid with out_ready held high.
        bus.out_ready = 1'b1;
        send(24'hFF1551);
        expect_res("ff1551", 3'd3, 10'd0, 1'b1, 5);
        @(negedge clk);
        chk("ff1551_drop", bus.out_valid, 1'b0);
        chk("ff1551_rdy",  bus.in_ready, 1'b1);
        chk("ff1551_keep", bus.out_color, 3'd3);

        // Exact hit at index 0, then the next pixel waits out the handshake cycle.
        send(24'hAAAAAA);
        expect_res("aaaaaa", 3'd0, 10'd0, 1'b1, 2);
        bus.in_valid = 1'b1;
        bus.in_rgb   = 24'h000001;
        @(negedge clk);
        chk("aaaaaa_next_rdy", bus.in_ready, 1'b1);
        chk("aaaaaa_drop",     bus.out_valid, 1'b0);
        send(24'h000001);
        expect_res("000001", 3'd1, 10'd1, 1'b0, 9);
        @(negedge clk);

        send(24'h0090FE);
        expect_res("0090fe", 3'd6, 10'd2, 1'b0, 9);
        @(negedge clk);
        send(24'h7F7F7F);
        expect_res("7f7f7f", 3'd0, 10'd129, 1'b0, 9);
        @(negedge clk);
        // Equidistant (101) from entries 0 and 4: lower index wins.
        send(24'hB09065);
        expect_res("tie", 3'd0, 10'd101, 1'b0, 9);
        @(negedge clk);

        // Backpressure with the next pixel already waiting.
        bus.out_ready = 1'b0;
        send(24'hBF8718);
        expect_res("bf8718", 3'd4, 10'd0, 1'b1, 6);
        bus.in_valid = 1'b1;
        bus.in_rgb   = 24'h5EFF00;
        for (int i = 0; i < 6; i++) begin
            chk("bp_valid", bus.out_valid, 1'b1);
            chk("bp_color", bus.out_color, 3'd4);
            chk("bp_dist",  bus.out_dist, 10'd0);
            chk("bp_rdy",   bus.in_ready, 1'b0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        chk("bp_hs_rdy", bus.in_ready, 1'b0);
        @(negedge clk);
        chk("bp_after_rdy",   bus.in_ready, 1'b1);
        chk("bp_after_valid", bus.out_valid, 1'b0);
        send(24'h5EFF00);
        expect_res("5eff00", 3'd5, 10'd0, 1'b1, 7);
        @(negedge clk);

        // Reset in cycle 4 of a search discards the pixel.
        send(24'h02006B);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", bus.out_valid, 1'b0);
        chk("mid_rst_rdy",   bus.in_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_valid) cnt++;
        end
        chk("mid_rst_no_valid", cnt, 0);
        send(24'hFFFFFF);
        expect_res("ffffff", 3'd2, 10'd0, 1'b1, 4);
        @(negedge clk);

        // Random pixels with idle gaps and output stalls against the model.
        for (int n = 0; n < 1500; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if ($urandom_range(0, 1) == 0) begin
                p = pal[$urandom_range(0, 7)] ^ 24'($urandom_range(0, 3) << ($urandom_range(0, 2) * 8));
            end else begin
                p = 24'($urandom);
            end
            model(p, mc, md);
            bus.out_ready = 1'($urandom_range(0, 1));
            send(p);
            wait_out(lat);
            chk($sformatf("rnd%0d_lat", n), lat, (md == 10'd0) ? 32'(mc) + 32'd2 : 32'd9);
            chk($sformatf("rnd%0d_color", n), bus.out_color, mc);
            chk($sformatf("rnd%0d_dist", n),  bus.out_dist, md);
            chk($sformatf("rnd%0d_exact", n), bus.out_exact, (md == 10'd0));
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin
                bus.out_ready = 1'b0;
                @(negedge clk);
                chk($sformatf("rnd%0d_hold", n), {bus.out_valid, bus.out_color}, {1'b1, mc});
            end
            bus.out_ready = 1'b1;
            @(negedge clk);
            chk($sformatf("rnd%0d_drop", n), bus.out_valid, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
